instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
Sequencer between the program RAM and the instruction register / control unit of the 8-bit processor. Each instruction is 3 bytes: opcode, operand1, operand2. The block owns the PC and reads the 3 bytes sequentially from the synchronous RAM. It presents the assembled instruction to the control unit with a valid/ready handshake and supports PC redirect for jumps.

Parameters:
DATA_W, 8, width of a RAM byte and of each instruction field
ADDR_W, 8, RAM address / PC width; PC arithmetic is modulo 2^ADDR_W
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
fetch_en  input  1  1 = fetching allowed; sampled only at an instruction boundary
mem_addr  output  ADDR_W  RAM read address
mem_rd_en  output  1  RAM read strobe
mem_data  input  DATA_W  RAM read data, valid the cycle after mem_rd_en
pc_load  input  1  redirect request from the control unit
pc_load_value  input  ADDR_W  redirect target
instr_valid  output  1  IR fields hold a complete instruction
instr_ready  input  1  control unit accepts the instruction
IR_opcode  output  DATA_W  byte at PC
IR_operand1  output  DATA_W  byte at PC+1
IR_operand2  output  DATA_W  byte at PC+2
PC_adress  output  ADDR_W  address of the instruction being fetched or held

Behaviour:
- Reset (async, rst=1): state=IDLE, PC=RESET_PC, mem_rd_en=0, mem_addr=0, instr_valid=0, all IR fields=0. Reset mid-fetch discards partial bytes with no stale valid.
- States: IDLE, F0, F1, F2, CAP, VALID.
- IDLE: mem_rd_en=0. If fetch_en=1, go to F0.
- F0: mem_addr=PC, mem_rd_en=1. Go to F1.
- F1: mem_addr=PC+1, mem_rd_en=1, IR_opcode<=mem_data. Go to F2.
- F2: mem_addr=PC+2, mem_rd_en=1, IR_operand1<=mem_data. Go to CAP.
- CAP: mem_rd_en=0, IR_operand2<=mem_data. Go to VALID.
- VALID: instr_valid=1 (registered, asserted only in this state). IR fields and PC_adress stay stable until the handshake.
  - Handshake when instr_valid & instr_ready at a rising edge: PC<=PC+3.
  - After the handshake, go to F0 if fetch_en=1, else IDLE.
- Timing: F0 to instr_valid=1 is 4 cycles. With ready held high, throughput is 1 instruction per 5 cycles.
- Byte addresses are computed modulo 2^ADDR_W. Example: PC=0xFE reads 0xFE, 0xFF, 0x00, and the next PC is 0x01.
- IR fields update only in F1/F2/CAP. Partially fetched fields are never exposed, because instr_valid=0 outside VALID.
- pc_load=1 in any non-IDLE state: PC<=pc_load_value, next state F0, instr_valid=0 from the next cycle. In-flight RAM data is discarded.
- pc_load=1 in IDLE: PC is loaded. The next state is F0 only if fetch_en=1.
- pc_load together with a VALID handshake in the same cycle: the instruction counts as consumed, but PC takes pc_load_value, not PC+3. pc_load has priority for the PC update.
- fetch_en=0 during F0..CAP does not abort the fetch. The current instruction completes and is handed over, then the FSM goes to IDLE.
- mem_addr holds its last value when mem_rd_en=0.
- PC_adress = PC at all times.

Test Plan:
- Reset then basic fetch: release rst with fetch_en=1, instr_ready=1, RAM[0..8]=01 00 02 01 01 02 03 00 01 -> three instructions (01,00,02) @PC 0, (01,01,02) @3, (03,00,01) @6. instr_valid rises 4 cycles after each F0 entry and lasts 1 cycle each.
- Backpressure: instr_ready=0 for 6 cycles while valid -> instr_valid, IR fields and PC_adress stay stable at 0x00/01,00,02. PC becomes 0x03 one cycle after ready rises.
- Redirect mid-fetch: pc_load=1, pc_load_value=0x06 during F1 of the instruction at 0x00 -> no valid for it. The next valid presents 03,00,01 with PC_adress=0x06.
- Redirect plus handshake in the same cycle: pc_load_value=0x03 with valid&ready -> next instruction fetched from 0x03, not 0x03+3.
- Wrap-around: pc_load_value=0xFE, RAM[FE]=AA, RAM[FF]=BB, RAM[00]=CC -> IR=AA,BB,CC and the next PC_adress=0x01.
- Reset mid-fetch and fetch_en: assert rst during F2 -> all outputs go to 0 immediately and PC=RESET_PC. With fetch_en=0 after one handshake, the FSM sits in IDLE with mem_rd_en=0 until fetch_en rises.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch sequencer for the 8-bit processor. Owns the program counter, reads the
// three bytes of each instruction (opcode, operand1, operand2) from a
// synchronous program RAM, and hands the assembled instruction to the control
// unit over a valid/ready handshake. Supports PC redirects for jumps.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   fetch_en       fetching allowed; only looked at on an instruction boundary
//   mem_addr       RAM read address (holds its value while mem_rd_en=0)
//   mem_rd_en      RAM read strobe
//   mem_data       RAM read data, valid the cycle after mem_rd_en
//   pc_load        redirect request from the control unit
//   pc_load_value  redirect target
//   instr_valid    IR fields hold a complete instruction
//   instr_ready    control unit accepts the instruction
//   IR_opcode      byte at PC
//   IR_operand1    byte at PC+1
//   IR_operand2    byte at PC+2
//   PC_adress      address of the instruction being fetched or held
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_value,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] IR_opcode,
  output logic [DATA_W-1:0] IR_operand1,
  output logic [DATA_W-1:0] IR_operand2,
  output logic [ADDR_W-1:0] PC_adress
);

  typedef enum logic [2:0] {
    IDLE,
    F0,
    F1,
    F2,
    CAP,
    VALID
  } state_t;

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO     = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(3);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;

  // Next state and next PC. Address arithmetic wraps naturally at ADDR_W bits.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      IDLE: begin
        if (pc_load)  pc_nxt    = pc_load_value;
        if (fetch_en) state_nxt = F0;
      end
      F0:  state_nxt = F1;
      F1:  state_nxt = F2;
      F2:  state_nxt = CAP;
      CAP: state_nxt = VALID;
      VALID: begin
        if (instr_ready) begin
          pc_nxt    = pc + STEP;
          state_nxt = fetch_en ? F0 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A redirect outside IDLE wins over everything, including a handshake in
    // the same cycle: the instruction is consumed but the PC takes the target.
    if (pc_load && (state != IDLE)) begin
      pc_nxt    = pc_load_value;
      state_nxt = F0;
    end
  end

  // State, PC and all outputs are registered. Outputs are decoded from the
  // state being entered so they are valid for the whole of that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= PC_INIT;
      mem_addr    <= '0;
      mem_rd_en   <= 1'b0;
      instr_valid <= 1'b0;
      IR_opcode   <= '0;
      IR_operand1 <= '0;
      IR_operand2 <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; blocking ones would make later lines see new values.
      state       <= state_nxt;
      pc          <= pc_nxt;
      mem_rd_en   <= (state_nxt == F0) || (state_nxt == F1) || (state_nxt == F2);
      instr_valid <= (state_nxt == VALID);

      case (state_nxt)
        F0:      mem_addr <= pc_nxt;
        F1:      mem_addr <= pc_nxt + ONE;
        F2:      mem_addr <= pc_nxt + TWO;
        default: mem_addr <= mem_addr;
      endcase

      // RAM data arriving during a redirect belongs to the abandoned fetch.
      if (!pc_load) begin
        case (state)
          F1:      IR_opcode   <= mem_data;
          F2:      IR_operand1 <= mem_data;
          CAP:     IR_operand2 <= mem_data;
          default: ;
        endcase
      end
    end
  end

  assign PC_adress = pc;

endmodule
